pipelined_divide: RTL and testbench



---
 rtl/divide_pkg.sv | 19 +
 rtl/divide_stage.sv | 78 +++++++
 rtl/pipelined_divide.sv | 147 ++++++++++++++
 tb/tb_pipelined_divide.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
// Shared types and elaboration helpers for the pipelined restoring divider.
package divide_pkg;

  typedef struct packed {
    logic dbz;
    logic ovf;
    logic neg_q;
    logic neg_r;
  } div_flags_t;

  function automatic int steps_per_stage(input int data_width, input int num_stages);
    return data_width / num_stages;
  endfunction

  function automatic bit stages_divide_width(input int data_width, input int num_stages);
    return (num_stages >= 1) && (data_width % num_stages == 0);
  endfunction

endpackage

// File: rtl/divide_stage.sv
// One iteration stage: STEPS restoring division steps feeding a stallable register.
module divide_stage
  import divide_pkg::*;
#(
  parameter int W     = 32,
  parameter int TW    = 4,
  parameter int STEPS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          in_valid,
  input  logic [W-1:0]  in_rem,
  input  logic [W-1:0]  in_quo,
  input  logic [W-1:0]  in_den,
  input  logic [W-1:0]  in_num,
  input  div_flags_t    in_flags,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [W-1:0]  out_rem,
  output logic [W-1:0]  out_quo,
  output logic [W-1:0]  out_den,
  output logic [W-1:0]  out_num,
  output div_flags_t    out_flags,
  output logic [TW-1:0] out_tag
);

  typedef struct packed {
    logic          vld;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  den;
    logic [W-1:0]  num;
    div_flags_t    flags;
    logic [TW-1:0] tag;
  } stage_t;

  stage_t        st;
  logic [W-1:0]  r, q;
  logic [W:0]    rt, diff;

  // quo shifts the dividend out MSB-first while quotient bits shift in at the LSB
  always_comb begin
    r    = in_rem;
    q    = in_quo;
    rt   = '0;
    diff = '0;
    for (int i = 0; i < STEPS; i++) begin
      rt   = {r, q[W-1]};
      diff = rt - {1'b0, in_den};
      if (!diff[W]) begin
        r = diff[W-1:0];
        q = {q[W-2:0], 1'b1};
      end else begin
        r = rt[W-1:0];
        q = {q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= '0;
    end else if (load) begin
      st <= '{vld: in_valid, rem: r, quo: q, den: in_den, num: in_num,
              flags: in_flags, tag: in_tag};
    end
  end

  assign out_valid = st.vld;
  assign out_rem   = st.rem;
  assign out_quo   = st.quo;
  assign out_den   = st.den;
  assign out_num   = st.num;
  assign out_flags = st.flags;
  assign out_tag   = st.tag;

endmodule

// File: rtl/pipelined_divide.sv
// Fully pipelined signed/unsigned divider: prep stage, NUM_STAGES iteration stages, output stage.
module pipelined_divide
  import divide_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  divide_ready_in,
  input  logic                  divide_valid_in,
  input  logic                  divide_signed_in,
  input  logic [DATA_WIDTH-1:0] divide_numer_in,
  input  logic [DATA_WIDTH-1:0] divide_denom_in,
  input  logic [TAG_WIDTH-1:0]  divide_tag_in,
  input  logic                  divide_ready_out,
  output logic                  divide_valid_out,
  output logic [DATA_WIDTH-1:0] divide_quotient_out,
  output logic [DATA_WIDTH-1:0] divide_remain_out,
  output logic [TAG_WIDTH-1:0]  divide_tag_out,
  output logic                  divide_dbz_out,
  output logic                  divide_ovf_out
);

  localparam int W     = DATA_WIDTH;
  localparam int N     = NUM_STAGES;
  localparam int STEPS = steps_per_stage(DATA_WIDTH, NUM_STAGES);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  if (!stages_divide_width(DATA_WIDTH, NUM_STAGES)) begin : g_bad_cfg
    $error("DATA_WIDTH must be a multiple of NUM_STAGES");
  end

  // index 0 is the prep register, 1..N the iteration stages
  logic [N:0]                vld_pipe;
  logic [N:0][W-1:0]         st_rem, st_quo, st_den, st_num;
  div_flags_t [N:0]          st_flags;
  logic [N:0][TAG_WIDTH-1:0] st_tag;
  logic [N+1:0]              adv;

  logic                 p_vld;
  logic [W-1:0]         p_quo, p_den, p_num;
  div_flags_t           p_flags;
  logic [TAG_WIDTH-1:0] p_tag;

  // advance chain from the output back to prep; an empty stage always advances
  always_comb begin
    adv      = '0;
    adv[N+1] = ~divide_valid_out | divide_ready_out;
    for (int k = N; k >= 0; k--) adv[k] = ~vld_pipe[k] | adv[k+1];
  end
  assign divide_ready_in = adv[0];

  logic         neg_n, neg_d;
  logic [W-1:0] abs_n, abs_d;
  assign neg_n = divide_signed_in & divide_numer_in[W-1];
  assign neg_d = divide_signed_in & divide_denom_in[W-1];
  assign abs_n = neg_n ? -divide_numer_in : divide_numer_in;
  assign abs_d = neg_d ? -divide_denom_in : divide_denom_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld   <= 1'b0;
      p_quo   <= '0;
      p_den   <= '0;
      p_num   <= '0;
      p_flags <= '0;
      p_tag   <= '0;
    end else if (adv[0]) begin
      p_vld         <= divide_valid_in;
      p_quo         <= abs_n;
      p_den         <= abs_d;
      p_num         <= divide_numer_in;
      p_flags.dbz   <= (divide_denom_in == '0);
      p_flags.ovf   <= divide_signed_in & (divide_numer_in == MIN_VAL) & (&divide_denom_in);
      p_flags.neg_q <= neg_n ^ neg_d;
      p_flags.neg_r <= neg_n;
      p_tag         <= divide_tag_in;
    end
  end

  assign vld_pipe[0] = p_vld;
  assign st_rem[0]   = '0;
  assign st_quo[0]   = p_quo;
  assign st_den[0]   = p_den;
  assign st_num[0]   = p_num;
  assign st_flags[0] = p_flags;
  assign st_tag[0]   = p_tag;

  for (genvar k = 1; k <= N; k++) begin : g_stage
    divide_stage #(.W(W), .TW(TAG_WIDTH), .STEPS(STEPS)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (adv[k]),
      .in_valid (vld_pipe[k-1]),
      .in_rem   (st_rem[k-1]),
      .in_quo   (st_quo[k-1]),
      .in_den   (st_den[k-1]),
      .in_num   (st_num[k-1]),
      .in_flags (st_flags[k-1]),
      .in_tag   (st_tag[k-1]),
      .out_valid(vld_pipe[k]),
      .out_rem  (st_rem[k]),
      .out_quo  (st_quo[k]),
      .out_den  (st_den[k]),
      .out_num  (st_num[k]),
      .out_flags(st_flags[k]),
      .out_tag  (st_tag[k])
    );
  end

  logic [W-1:0] o_q, o_r;
  div_flags_t   lf;
  assign lf = st_flags[N];

  always_comb begin
    o_q = lf.neg_q ? -st_quo[N] : st_quo[N];
    o_r = lf.neg_r ? -st_rem[N] : st_rem[N];
    if (lf.dbz) begin
      o_q = '1;
      o_r = st_num[N];
    end else if (lf.ovf) begin
      o_q = MIN_VAL;
      o_r = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divide_valid_out    <= 1'b0;
      divide_quotient_out <= '0;
      divide_remain_out   <= '0;
      divide_tag_out      <= '0;
      divide_dbz_out      <= 1'b0;
      divide_ovf_out      <= 1'b0;
    end else if (adv[N+1]) begin
      divide_valid_out    <= vld_pipe[N];
      divide_quotient_out <= o_q;
      divide_remain_out   <= o_r;
      divide_tag_out      <= st_tag[N];
      divide_dbz_out      <= lf.dbz;
      divide_ovf_out      <= lf.ovf & ~lf.dbz;
    end
  end

endmodule

// File: tb/tb_pipelined_divide.sv
// Directed vector table plus stall, bubble-collapse and reset sequences for pipelined_divide.
module tb_pipelined_divide;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 6;
  localparam int CAP = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          divide_ready_in;
  logic          divide_valid_in;
  logic          divide_signed_in;
  logic [W-1:0]  divide_numer_in;
  logic [W-1:0]  divide_denom_in;
  logic [TW-1:0] divide_tag_in;
  logic          divide_ready_out;
  logic          divide_valid_out;
  logic [W-1:0]  divide_quotient_out;
  logic [W-1:0]  divide_remain_out;
  logic [TW-1:0] divide_tag_out;
  logic          divide_dbz_out;
  logic          divide_ovf_out;

  always #5 clk = ~clk;

  pipelined_divide #(.DATA_WIDTH(W), .NUM_STAGES(4), .TAG_WIDTH(TW)) dut (
    .clk                (clk),
    .rst                (rst),
    .divide_ready_in    (divide_ready_in),
    .divide_valid_in    (divide_valid_in),
    .divide_signed_in   (divide_signed_in),
    .divide_numer_in    (divide_numer_in),
    .divide_denom_in    (divide_denom_in),
    .divide_tag_in      (divide_tag_in),
    .divide_ready_out   (divide_ready_out),
    .divide_valid_out   (divide_valid_out),
    .divide_quotient_out(divide_quotient_out),
    .divide_remain_out  (divide_remain_out),
    .divide_tag_out     (divide_tag_out),
    .divide_dbz_out     (divide_dbz_out),
    .divide_ovf_out     (divide_ovf_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            sgn;
    logic [W-1:0]  n;
    logic [W-1:0]  d;
    logic [TW-1:0] tag;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    bit            dbz;
    bit            ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    bit            dbz;
    bit            ovf;
  } exp_t;

  vec_t vt[15];

  function automatic exp_t model(input bit s, input logic [W-1:0] n, input logic [W-1:0] d,
                                 input logic [TW-1:0] tag);
    exp_t e;
    e.tag = tag; e.dbz = 0; e.ovf = 0;
    if (d == 0) begin
      e.q = '1; e.r = n; e.dbz = 1;
    end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 0; e.ovf = 1;
    end else if (s) begin
      e.q = $signed(n) / $signed(d);
      e.r = $signed(n) % $signed(d);
    end else begin
      e.q = n / d;
      e.r = n % d;
    end
    return e;
  endfunction

  task automatic drive(input bit v, input bit s, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [TW-1:0] t);
    divide_valid_in  = v;
    divide_signed_in = s;
    divide_numer_in  = n;
    divide_denom_in  = d;
    divide_tag_in    = t;
  endtask

  // one transaction with ready_out high; checks latency and all result fields
  task automatic run_one(input vec_t v, input string nm);
    int n;
    @(posedge clk); #1;
    drive(1, v.sgn, v.n, v.d, v.tag);
    check({nm, " ready_in"}, divide_ready_in, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    n = 1;
    while (!divide_valid_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, n, LAT);
    check({nm, " quotient"}, divide_quotient_out, v.q);
    check({nm, " remainder"}, divide_remain_out, v.r);
    check({nm, " tag"}, divide_tag_out, v.tag);
    check({nm, " dbz"}, divide_dbz_out, v.dbz);
    check({nm, " ovf"}, divide_ovf_out, v.ovf);
    @(posedge clk); #1;
    check({nm, " drained"}, divide_valid_out, 0);
  endtask

  // streaming engine: cycle-accurate ready_in expectation and in-order scoreboard
  bit saw_full;
  task automatic run_stream(input string nm, input int num, input int stall_from,
                            input int stall_len, input int gap_first, output int acc_at_release);
    exp_t          sb[$];
    exp_t          e;
    bit            s_a[32];
    logic [W-1:0]  n_a[32], d_a[32];
    int            sent = 0, got = 0, cyc = 0, inflight;
    saw_full = 0;
    acc_at_release = -1;
    for (int i = 0; i < num; i++) begin
      s_a[i] = 1'($urandom_range(0, 1));
      n_a[i] = $urandom;
      d_a[i] = $urandom_range(1, 5000);
      if (s_a[i] && $urandom_range(0, 1) == 1) d_a[i] = -d_a[i];
      if (i == 5) d_a[i] = 0;
    end
    @(posedge clk); #1;
    while (got < num && cyc < 400) begin
      divide_ready_out = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (cyc == stall_from + stall_len) acc_at_release = sent;
      if (sent < num && (sent != 1 || cyc >= gap_first))
        drive(1, s_a[sent], n_a[sent], d_a[sent], 4'(sent));
      else
        drive(0, 0, 0, 0, 0);
      @(negedge clk);
      inflight = sent - got;
      if (!divide_ready_in) saw_full = 1;
      check({nm, " ready_in"}, divide_ready_in, divide_ready_out | (inflight < CAP));
      if (divide_valid_out) begin
        if (sb.size() == 0) begin
          check({nm, " spurious valid_out"}, 1, 0);
        end else begin
          e = sb[0];
          check({nm, " result"},
                {divide_quotient_out, divide_remain_out, divide_tag_out, divide_dbz_out, divide_ovf_out},
                {e.q, e.r, e.tag, e.dbz, e.ovf});
          if (divide_ready_out) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      if (divide_valid_in && divide_ready_in) begin
        sb.push_back(model(s_a[sent], n_a[sent], d_a[sent], 4'(sent)));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " completed"}, got, num);
    drive(0, 0, 0, 0, 0);
    divide_ready_out = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int   acc, bad;
    vec_t v;
    vt[0]  = '{0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          0, 0};
    vt[1]  = '{1, 32'hFFFF_FFF9,  32'd2,          4'd1,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 0};
    vt[2]  = '{1, 32'd7,          32'hFFFF_FFFE,  4'd2,  32'hFFFF_FFFD,  32'd1,          0, 0};
    vt[3]  = '{0, 32'd5,          32'd0,          4'd4,  32'hFFFF_FFFF,  32'd5,          1, 0};
    vt[4]  = '{1, 32'd5,          32'd0,          4'd5,  32'hFFFF_FFFF,  32'd5,          1, 0};
    vt[5]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  4'd6,  32'h8000_0000,  32'd0,          0, 1};
    vt[6]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  4'd7,  32'd0,          32'h8000_0000,  0, 0};
    vt[7]  = '{0, 32'hFFFF_FFFF,  32'd1,          4'd8,  32'hFFFF_FFFF,  32'd0,          0, 0};
    vt[8]  = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  4'd9,  32'd3,          32'hFFFF_FFFF,  0, 0};
    vt[9]  = '{1, 32'h8000_0000,  32'd2,          4'hA,  32'hC000_0000,  32'd0,          0, 0};
    vt[10] = '{0, 32'd0,          32'd3,          4'hB,  32'd0,          32'd0,          0, 0};
    vt[11] = '{1, 32'hFFFF_FFFB,  32'd0,          4'hC,  32'hFFFF_FFFF,  32'hFFFF_FFFB,  1, 0};
    vt[12] = '{0, 32'h1234_5678,  32'h0001_0000,  4'hD,  32'h0000_1234,  32'h0000_5678,  0, 0};
    vt[13] = '{0, 32'd7,          32'hFFFF_FFFE,  4'hE,  32'd0,          32'd7,          0, 0};
    vt[14] = '{1, 32'h8000_0000,  32'd1,          4'hF,  32'h8000_0000,  32'd0,          0, 0};

    rst = 0;
    divide_ready_out = 1;
    drive(0, 0, 0, 0, 0);
    #1;
    check("reset valid_out", divide_valid_out, 0);
    check("reset outputs",
          {divide_quotient_out, divide_remain_out, divide_tag_out, divide_dbz_out, divide_ovf_out}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    check("ready_in after reset", divide_ready_in, 1);

    for (int i = 0; i < 15; i++) begin
      v = vt[i];
      run_one(v, $sformatf("vec%0d", i));
    end

    run_stream("stall", 20, 8, 10, 0, acc);
    check("stall ready_in fell", saw_full, 1);

    run_stream("bubble", 6, 0, 20, 8, acc);
    check("bubble accepted before release", acc, 6);

    // reset with four transactions in flight and output stalled
    @(posedge clk); #1;
    divide_ready_out = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'd1000 + 32'(i), 32'd3, 4'(i));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("pre-reset valid_out", divide_valid_out, 1);
    rst = 0;
    #1;
    check("async reset valid_out", divide_valid_out, 0);
    check("async reset tag", divide_tag_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    divide_ready_out = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (divide_valid_out) bad++;
    end
    check("no stale result after reset", bad, 0);
    run_one(vt[0], "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
